// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC redirect logic.
//   pc_state_e       : redirect FSM state (IDLE, SLOTS)
//   DEFAULT_RESET_PC : default boot fetch address
//   MAX_DELAY_SLOTS  : largest supported branch delay slot count
//   ALIGN_BITS       : low address bits forced to zero on every redirect
package pc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SLOTS = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int unsigned MAX_DELAY_SLOTS  = 7;
  localparam int unsigned ALIGN_BITS       = 2;

endpackage

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC generator with a configurable number of branch delay slots
// and a synchronous exception redirect.
//   clk, rst           : clock, synchronous active-high reset
//   en                 : pipeline advance (0 = IF stall)
//   br_valid/br_target : taken branch held in ID and its resolved target
//   exc_valid/exc_vector : exception redirect request and handler address
//   pc_f, pc_plus4_f   : registered fetch address and its successor
//   flush_f            : comb, kill the IF instruction (zero-slot config only)
//   redirect_busy      : delay slots still pending before the redirect
//   misalign_err       : one-cycle pulse, accepted target was not word aligned
//   slot_branch_err    : sticky, a new branch appeared while slots were pending
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     DELAY_SLOTS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_vector,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            flush_f,
  output logic            redirect_busy,
  output logic            misalign_err,
  output logic            slot_branch_err
);

  localparam int unsigned     CNT_W      = (DELAY_SLOTS < 1) ? 1 : $clog2(DELAY_SLOTS + 1);
  localparam logic [CNT_W-1:0] REM0      = (DELAY_SLOTS == 0) ? '0 : CNT_W'(DELAY_SLOTS - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << ALIGN_BITS) - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(4);

  if (DELAY_SLOTS > MAX_DELAY_SLOTS) begin : g_bad_slots
    $error("pc_redirect_unit: DELAY_SLOTS exceeds MAX_DELAY_SLOTS");
  end

  pc_state_e        state;
  logic [CNT_W-1:0] rem;
  logic             hold;
  logic [XLEN-1:0]  tgt;
  logic             br_valid_q;
  logic             accept;
  logic [XLEN-1:0]  tgt_in;
  logic [XLEN-1:0]  exc_pc;

  // hold blocks a branch still sitting in ID from being taken a second time
  assign accept  = (state == IDLE) && br_valid && !hold;
  assign tgt_in  = br_target & ALIGN_MASK;
  assign exc_pc  = exc_vector & ALIGN_MASK;
  assign flush_f = accept && en && (DELAY_SLOTS == 0) && !exc_valid && !rst;
  assign redirect_busy = (state != IDLE);

  // Redirect FSM, delay-slot counter, PC pair and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rem             <= '0;
      hold            <= 1'b0;
      tgt             <= '0;
      br_valid_q      <= 1'b0;
      pc_f            <= RESET_PC;
      pc_plus4_f      <= RESET_PC + STEP;
      misalign_err    <= 1'b0;
      slot_branch_err <= 1'b0;
    end else begin
      br_valid_q   <= br_valid;
      misalign_err <= 1'b0;
      if (exc_valid) begin
        // exception wins over stall and abandons any pending target
        pc_f       <= exc_pc;
        pc_plus4_f <= exc_pc + STEP;
        state      <= IDLE;
        rem        <= '0;
        hold       <= br_valid;
      end else begin
        hold <= hold & br_valid;
        case (state)
          IDLE: begin
            if (accept) begin
              tgt          <= tgt_in;
              misalign_err <= |br_target[ALIGN_BITS-1:0];
              if (en) begin
                if (REM0 == '0) begin
                  pc_f       <= tgt_in;
                  pc_plus4_f <= tgt_in + STEP;
                  hold       <= 1'b1;
                end else begin
                  pc_f       <= pc_plus4_f;
                  pc_plus4_f <= pc_plus4_f + STEP;
                  rem        <= REM0 - CNT_W'(1);
                  state      <= SLOTS;
                end
              end else begin
                rem   <= REM0;
                state <= SLOTS;
              end
            end else if (en) begin
              pc_f       <= pc_plus4_f;
              pc_plus4_f <= pc_plus4_f + STEP;
            end
          end
          SLOTS: begin
            if (br_valid && !br_valid_q) begin
              slot_branch_err <= 1'b1;
            end
            if (en) begin
              if (rem == '0) begin
                pc_f       <= tgt;
                pc_plus4_f <= tgt + STEP;
                hold       <= br_valid;
                state      <= IDLE;
              end else begin
                pc_f       <= pc_plus4_f;
                pc_plus4_f <= pc_plus4_f + STEP;
                rem        <= rem - CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: four instances (DELAY_SLOTS 0..3) share one
// stimulus stream; each row carries the expected outputs of all four.
module tb_pc_redirect_unit;

  localparam int unsigned NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_vector = '0;

  logic [31:0]   pc  [NI];
  logic [31:0]   pc4 [NI];
  logic [NI-1:0] flush, busy, mis, sbe;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pc_redirect_unit #(.DELAY_SLOTS(g)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .br_valid        (br_valid),
      .br_target       (br_target),
      .exc_valid       (exc_valid),
      .exc_vector      (exc_vector),
      .pc_f            (pc[g]),
      .pc_plus4_f      (pc4[g]),
      .flush_f         (flush[g]),
      .redirect_busy   (busy[g]),
      .misalign_err    (mis[g]),
      .slot_branch_err (sbe[g])
    );
  end

  typedef struct {
    logic          rst;
    logic          en;
    logic          bv;
    logic [31:0]   bt;
    logic          ev;
    logic [31:0]   evec;
    logic [31:0]   pc [NI];
    logic [NI-1:0] flush;
    logic [NI-1:0] busy;
    logic [NI-1:0] mis;
    logic [NI-1:0] sbe;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic b,
                              input logic [31:0] t, input logic x, input logic [31:0] xv,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input logic [3:0] fl, input logic [3:0] bs,
                              input logic [3:0] ms, input logic [3:0] sb);
    vec_t v;
    v.rst = r; v.en = e; v.bv = b; v.bt = t; v.ev = x; v.evec = xv;
    v.pc[0] = p0; v.pc[1] = p1; v.pc[2] = p2; v.pc[3] = p3;
    v.flush = fl; v.busy = bs; v.mis = ms; v.sbe = sb;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [NI-1:0] act, input logic [NI-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one row, check comb flush before the edge, registered outputs after it
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; br_valid = v.bv; br_target = v.bt;
    exc_valid = v.ev; exc_vector = v.evec;
    #1;
    chk4($sformatf("flush_f row%0d", idx), flush, v.flush);
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard row%0d: got empty queue expected one entry", idx);
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        chk32($sformatf("pc_f d%0d row%0d", i, idx), pc[i], e.pc[i]);
        chk32($sformatf("pc_plus4_f d%0d row%0d", i, idx), pc4[i], e.pc[i] + 32'd4);
      end
      chk4($sformatf("redirect_busy row%0d", idx), busy, e.busy);
      chk4($sformatf("misalign_err row%0d", idx), mis, e.mis);
      chk4($sformatf("slot_branch_err row%0d", idx), sbe, e.sbe);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst en bv target        exc vector        d0            d1            d2            d3            flush    busy     mis      sbe
    tbl.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,         32'h3000,     32'h3000,     32'h3000,     32'h3000,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,         32'h3000,     32'h3000,     32'h3000,     32'h3000,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h3004,     32'h3004,     32'h3004,     32'h3004,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h3008,     32'h3008,     32'h3008,     32'h3008,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // branch to 4000 accepted at 3008, held in ID for three cycles
    tbl.push_back(mk(0, 1, 1, 32'h4000,   0, 32'h0,         32'h4000,     32'h4000,     32'h300C,     32'h300C,     4'b0001, 4'b1100, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 32'h4000,   0, 32'h0,         32'h4004,     32'h4004,     32'h4000,     32'h3010,     4'b0000, 4'b1000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 32'h4000,   0, 32'h0,         32'h4008,     32'h4008,     32'h4004,     32'h4000,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h400C,     32'h400C,     32'h4008,     32'h4004,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // misaligned target, then two stall cycles mid-slots
    tbl.push_back(mk(0, 1, 1, 32'h5002,   0, 32'h0,         32'h5000,     32'h5000,     32'h400C,     32'h4008,     4'b0001, 4'b1100, 4'b1111, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,         32'h5000,     32'h5000,     32'h400C,     32'h4008,     4'b0000, 4'b1100, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,         32'h5000,     32'h5000,     32'h400C,     32'h4008,     4'b0000, 4'b1100, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h5004,     32'h5004,     32'h5000,     32'h400C,     4'b0000, 4'b1000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h5008,     32'h5008,     32'h5004,     32'h5000,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // exception during slots with en=0 drops the pending target
    tbl.push_back(mk(0, 1, 1, 32'h4000,   0, 32'h0,         32'h4000,     32'h4000,     32'h5008,     32'h5004,     4'b0001, 4'b1100, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 32'h180,       32'h180,      32'h180,      32'h180,      32'h180,      4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h184,      32'h184,      32'h184,      32'h184,      4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h188,      32'h188,      32'h188,      32'h188,      4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // exception beats a same-cycle branch; the stalled branch never fires after
    tbl.push_back(mk(0, 1, 1, 32'h6001,   1, 32'h200,       32'h200,      32'h200,      32'h200,      32'h200,      4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 32'h6001,   0, 32'h0,         32'h204,      32'h204,      32'h204,      32'h204,      4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h208,      32'h208,      32'h208,      32'h208,      4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // wrap at the top of the address space
    tbl.push_back(mk(0, 0, 0, 32'h0,      1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // branch rising during slots, stalled accept, sticky slot error
    tbl.push_back(mk(0, 1, 1, 32'h7000,   0, 32'h0,         32'h7000,     32'h7000,     32'h4,        32'h4,        4'b0001, 4'b1100, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,         32'h7000,     32'h7000,     32'h4,        32'h4,        4'b0000, 4'b1100, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 0, 1, 32'h8000,   0, 32'h0,         32'h7000,     32'h7000,     32'h4,        32'h4,        4'b0000, 4'b1111, 4'b0000, 4'b1100));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h8000,     32'h8000,     32'h7000,     32'h8,        4'b0000, 4'b1000, 4'b0000, 4'b1100));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h8004,     32'h8004,     32'h7004,     32'h7000,     4'b0000, 4'b0000, 4'b0000, 4'b1100));
    tbl.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,         32'h3000,     32'h3000,     32'h3000,     32'h3000,     4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,         32'h3004,     32'h3004,     32'h3004,     32'h3004,     4'b0000, 4'b0000, 4'b0000, 4'b0000));

    for (int r = 0; r < tbl.size(); r++) begin
      apply(tbl[r], r);
    end

    // reset during slots: the pending 9000 target must never appear
    apply(mk(0, 1, 1, 32'h9000, 0, 32'h0, 32'h9000, 32'h9000, 32'h3008, 32'h3008,
             4'b0001, 4'b1100, 4'b0000, 4'b0000), 100);
    apply(mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h3000, 32'h3000, 32'h3000, 32'h3000,
             4'b0000, 4'b0000, 4'b0000, 4'b0000), 101);
    for (int k = 1; k <= 4; k++) begin
      logic [31:0] p;
      p = 32'h3000 + 32'(4 * k);
      apply(mk(0, 1, 0, 32'h0, 0, 32'h0, p, p, p, p,
               4'b0000, 4'b0000, 4'b0000, 4'b0000), 101 + k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
